uart_tx_periph: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 51 +++++
 rtl/uart_tx_periph.sv | 146 ++++++++++++++
 tb/tb_uart_tx_periph.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit peripheral: register offsets,
// STATUS bit positions and the transmitter state encoding.
package uart_pkg;

  localparam logic [7:0] UART_TXDATA  = 8'h00;
  localparam logic [7:0] UART_STATUS  = 8'h04;
  localparam logic [7:0] UART_BAUDDIV = 8'h08;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit path; a push is accepted while full
// when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: register decode, frame FSM, baud timer.
// Define UART_TX_PARITY_EN for 8E1 frames; default build sends 8N1.
//
// state   | meaning
// S_IDLE  | waiting for FIFO data; pops and latches divisor on entry to START
// S_START | start bit (tx low)
// S_DATA  | eight data bits, LSB first
// S_PAR   | even parity bit (parity build only)
// S_STOP  | stop bit (tx high)
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [15:0] DIV_RST = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  input  logic [31:0] sdata,
  input  logic        wren,
  output logic [31:0] ldata,
  output logic        tx
);

  localparam int CW = $clog2(DEPTH) + 1;

  uart_state_e   state, state_nx;
  logic [15:0]   div, period, baud_cnt;
  logic [7:0]    shift;
  logic [2:0]    bitcnt;
  logic          ovf, tx_nx, bit_end, push_req, ovf_set, ovf_clr;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [3:0]    count4;
  logic          unused_sdata;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  assign unused_sdata = ^sdata[31:16];
  assign count4       = 4'(fifo_count);
  assign push_req     = wren && (addr == UART_TXDATA);
  assign fifo_pop     = (state == S_IDLE) && !fifo_empty;
  assign ovf_set      = push_req && fifo_full && !fifo_pop;
  assign ovf_clr      = wren && (addr == UART_STATUS) && sdata[ST_OVF];
  assign bit_end      = (baud_cnt == '0);

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (sdata[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nx = state;
    tx_nx    = 1'b1;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nx = S_START;
      S_START: begin
        tx_nx = 1'b0;
        if (bit_end) state_nx = S_DATA;
      end
      S_DATA: begin
        tx_nx = shift[0];
`ifdef UART_TX_PARITY_EN
        if (bit_end && bitcnt == 3'd7) state_nx = S_PAR;
`else
        if (bit_end && bitcnt == 3'd7) state_nx = S_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      S_PAR: begin
        tx_nx = par;
        if (bit_end) state_nx = S_STOP;
      end
`endif
      S_STOP:  if (bit_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      div      <= DIV_RST;
      ovf      <= 1'b0;
      period   <= '0;
      baud_cnt <= '0;
      shift    <= '0;
      bitcnt   <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      tx    <= tx_nx;
      if (wren && addr == UART_BAUDDIV) div <= sdata[15:0];
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (fifo_pop) begin
        shift    <= fifo_dout;
        period   <= div;
        baud_cnt <= div;
        bitcnt   <= '0;
`ifdef UART_TX_PARITY_EN
        par      <= ^fifo_dout;
`endif
      end else if (state != S_IDLE) begin
        if (bit_end) begin
          baud_cnt <= period;
          if (state == S_DATA) begin
            shift  <= shift >> 1;
            bitcnt <= bitcnt + 1'b1;
          end
        end else begin
          baud_cnt <= baud_cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    ldata = '0;
    case (addr)
      UART_STATUS: begin
        ldata[ST_FULL]         = fifo_full;
        ldata[ST_EMPTY]        = fifo_empty;
        ldata[ST_BUSY]         = (state != S_IDLE);
        ldata[ST_OVF]          = ovf;
        ldata[ST_COUNT +: 4]   = count4;
      end
      UART_BAUDDIV: ldata[15:0] = div;
      default:      ldata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: expected frames are queued as bytes are
// stored, and a line monitor decodes tx and compares against the queue.
module tb_uart_tx_periph;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [7:0] b;
    int         div;
  } frame_t;

  logic        clk, rst, wren, tx;
  logic [7:0]  addr;
  logic [31:0] sdata, ldata;
  int          checks, errors;
  frame_t      exp_q[$];

  uart_tx_periph #(.DEPTH(8), .DIV_RST(16'd3)) dut (
    .clk(clk), .rst(rst), .addr(addr), .sdata(sdata),
    .wren(wren), .ldata(ldata), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr = a; sdata = d; wren = 1'b1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    wren = 1'b0; addr = a;
    #1 v = ldata;
  endtask

  task automatic push_exp(input logic [7:0] b, input int div);
    frame_t f;
    f.b = b; f.div = div;
    exp_q.push_back(f);
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rd(UART_STATUS, v);
      if (v[2:0] == 3'b010) begin ok = 1'b1; break; end
    end
    chk("wait_idle", {31'd0, ok}, 32'd1);
    repeat (3) @(posedge clk);
  endtask

  // Line monitor: decodes each frame cycle by cycle against the expected bit pattern.
  initial begin : monitor
    logic   prev, aborted;
    logic   bits[NBITS];
    frame_t f;
    int     per, bad;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin prev = 1'b1; continue; end
      if (prev && !tx) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          prev = tx;
          continue;
        end
        f = exp_q.pop_front();
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[1+k] = f.b[k];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^f.b;
`endif
        bits[NBITS-1] = 1'b1;
        per = f.div + 1;
        bad = 0;
        aborted = 1'b0;
        for (int i = 1; i < NBITS * per; i++) begin
          @(negedge clk);
          if (rst) begin aborted = 1'b1; break; end
          if (tx !== bits[i / per]) bad++;
        end
        if (!aborted) begin
          chk($sformatf("frame_%02h_badcycles", f.b), bad, 32'd0);
          @(negedge clk);
          if (!rst) chk("interframe_gap", {31'd0, tx}, 32'd1);
        end
        prev = 1'b1;
        continue;
      end
      prev = tx;
    end
  end

  initial begin : stim
    logic [31:0] v;
    logic [7:0]  b, b2;
    int          d, n, busy_cyc;
    checks = 0; errors = 0;
    rst = 1'b1; wren = 1'b0; addr = 8'h00; sdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and unused offsets
    chk("reset_tx", {31'd0, tx}, 32'd1);
    rd(UART_STATUS, v);  chk("reset_status", v, 32'h2);
    rd(UART_BAUDDIV, v); chk("reset_bauddiv", v, 32'd3);
    rd(UART_TXDATA, v);  chk("read_txdata", v, 32'd0);
    rd(8'h0C, v);        chk("read_0c", v, 32'd0);

    // First-frame latency from an idle, empty FIFO
    push_exp(8'h55, 3);
    wr(UART_TXDATA, 32'h55);
    @(posedge clk); #1 wren = 1'b0; addr = UART_STATUS;
    #1 chk("status_after_push", ldata, 32'h10);
    @(posedge clk); #2 chk("status_after_pop", ldata, 32'h06);
    chk("tx_high_before_start", {31'd0, tx}, 32'd1);
    @(posedge clk); #2 chk("tx_start_fall", {31'd0, tx}, 32'd0);
    wait_idle();

    // Randomized divisors and bursts
    for (int r = 0; r < 6; r++) begin
      d = $urandom_range(0, 3);
      wr(UART_BAUDDIV, d);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        push_exp(b, d);
        wr(UART_TXDATA, {24'd0, b});
      end
      rd(UART_BAUDDIV, v); chk("bauddiv_rw", v, d);
      wait_idle();
    end

    // Fill, overflow and overflow clear
    wr(UART_BAUDDIV, 3);
    for (int k = 0; k < 9; k++) begin
      b = 8'($urandom);
      push_exp(b, 3);
      wr(UART_TXDATA, {24'd0, b});
    end
    rd(UART_STATUS, v); chk("status_full", v, 32'h85);
    wr(UART_TXDATA, 32'hA5);
    rd(UART_STATUS, v); chk("status_ovf", v, 32'h8D);
    wr(UART_STATUS, 32'h08);
    rd(UART_STATUS, v); chk("status_ovf_clr", v, 32'h85);
    wait_idle();

    // Divisor change mid-frame applies to the next frame only
    b = 8'($urandom); b2 = 8'($urandom);
    push_exp(b, 3); push_exp(b2, 0);
    wr(UART_TXDATA, {24'd0, b});
    wr(UART_TXDATA, {24'd0, b2});
    rd(UART_STATUS, v);
    repeat (4) @(posedge clk);
    wr(UART_BAUDDIV, 0);
    rd(UART_BAUDDIV, v); chk("bauddiv_zero", v, 32'd0);
    wait_idle();

    // Reset during DATA bit 3
    wr(UART_BAUDDIV, 3);
    wr(UART_TXDATA, 32'hC3);
    push_exp(8'hC3, 3);
    @(posedge clk); #1 wren = 1'b0;
    repeat (18) @(posedge clk);
    #1 rst = 1'b1; addr = UART_STATUS;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_status", ldata, 32'h2);
    addr = UART_BAUDDIV;
    #1 chk("rst_bauddiv", ldata, 32'd3);

    // Store to an unused offset changes nothing
    wr(8'h0C, 32'hFFFF_FFFF);
    rd(UART_STATUS, v);  chk("unused_store_status", v, 32'h2);
    rd(UART_BAUDDIV, v); chk("unused_store_bauddiv", v, 32'd3);
    rd(8'h0C, v);        chk("unused_store_read", v, 32'd0);
    repeat (20) @(posedge clk);

    // One-cycle bits: busy duration equals the frame length
    wr(UART_BAUDDIV, 0);
    wr(UART_TXDATA, 32'h80);
    push_exp(8'h80, 0);
    busy_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1 wren = 1'b0; addr = UART_STATUS;
      #1 if (ldata[ST_BUSY]) busy_cyc++;
    end
    chk("busy_cycles_div0", busy_cyc, NBITS);
    wait_idle();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
